// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, mul/div wait with timeout and branch flush sequencing.
// Optional stall performance counter enabled by defining HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int BR_FLUSH_CYCLES = 1,
  parameter int MD_TIMEOUT      = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IDEX_MemRead,
  input  logic [3:0]  IDEX_Rd,
  input  logic [3:0]  IFID_Rs,
  input  logic [3:0]  IFID_Rt,
  input  logic        IFID_UseRt,
  input  logic        Branch_taken,
  input  logic        md_start,
  input  logic        md_done,
  output logic        PC_WRITE,
  output logic        IFID_WRITE,
  output logic        IFID_FLUSH,
  output logic        IDEX_FLUSH,
  output logic        md_abort,
  output logic        md_timeout,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BR_FLUSH = 2'd1,
    MD_WAIT  = 2'd2
  } state_t;

  localparam logic [7:0] MD_LAST   = 8'(MD_TIMEOUT - 1);
  localparam logic [1:0] BR_RELOAD = 2'(BR_FLUSH_CYCLES);

  state_t     state_reg, state_next;
  logic [7:0] md_cnt_reg, md_cnt_next;
  logic [1:0] br_cnt_reg, br_cnt_next;
  logic       load_use;

  always_comb begin
    load_use = IDEX_MemRead && (IDEX_Rd != 4'd0) &&
               ((IDEX_Rd == IFID_Rs) || (IFID_UseRt && (IDEX_Rd == IFID_Rt)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= RUN;
      md_cnt_reg <= 8'd0;
      br_cnt_reg <= 2'd0;
    end else begin
      state_reg  <= state_next;
      md_cnt_reg <= md_cnt_next;
      br_cnt_reg <= br_cnt_next;
    end
  end

  // The md_start issue cycle stalls like a load-use hazard, so the EX instruction is held
  // from issue until md_done or timeout.
  always_comb begin
    state_next  = state_reg;
    md_cnt_next = md_cnt_reg;
    br_cnt_next = br_cnt_reg;
    PC_WRITE    = 1'b1;
    IFID_WRITE  = 1'b1;
    IFID_FLUSH  = 1'b0;
    IDEX_FLUSH  = 1'b0;
    md_abort    = 1'b0;
    md_timeout  = 1'b0;

    if (!rst) begin
      PC_WRITE    = 1'b0;
      IFID_WRITE  = 1'b0;
      IFID_FLUSH  = 1'b1;
      IDEX_FLUSH  = 1'b1;
      state_next  = RUN;
      md_cnt_next = 8'd0;
      br_cnt_next = 2'd0;
    end else if (Branch_taken) begin
      IFID_FLUSH  = 1'b1;
      IDEX_FLUSH  = 1'b1;
      md_abort    = (state_reg == MD_WAIT);
      state_next  = BR_FLUSH;
      br_cnt_next = BR_RELOAD;
      md_cnt_next = 8'd0;
    end else begin
      case (state_reg)
        RUN: begin
          if (md_start || load_use) begin
            PC_WRITE   = 1'b0;
            IFID_WRITE = 1'b0;
            IDEX_FLUSH = 1'b1;
          end
          if (md_start) begin
            state_next  = MD_WAIT;
            md_cnt_next = 8'd0;
          end
        end
        MD_WAIT: begin
          if (md_done) begin
            state_next  = RUN;
            md_cnt_next = 8'd0;
          end else if (md_cnt_reg == MD_LAST) begin
            md_timeout  = 1'b1;
            state_next  = RUN;
            md_cnt_next = 8'd0;
          end else begin
            PC_WRITE    = 1'b0;
            IFID_WRITE  = 1'b0;
            IDEX_FLUSH  = 1'b1;
            md_cnt_next = md_cnt_reg + 8'd1;
          end
        end
        BR_FLUSH: begin
          IFID_FLUSH = 1'b1;
          IDEX_FLUSH = 1'b1;
          if (br_cnt_reg <= 2'd1) begin
            state_next  = RUN;
            br_cnt_next = 2'd0;
          end else begin
            br_cnt_next = br_cnt_reg - 2'd1;
          end
        end
        default: begin
          state_next  = RUN;
          md_cnt_next = 8'd0;
          br_cnt_next = 2'd0;
        end
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count_reg <= 16'h0000;
    end else if (!PC_WRITE && (stall_count_reg != 16'hFFFF)) begin
      stall_count_reg <= stall_count_reg + 16'h0001;
    end
  end

  assign stall_count = stall_count_reg;
`else
  assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic against
// a timestamp-based reference model. Perf-counter scenario runs only with HAZ_PERF_CNT_EN.
module tb_pipe_hazard_ctrl;

  localparam int BRC = 2;
  localparam int MDT = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        IDEX_MemRead;
  logic [3:0]  IDEX_Rd;
  logic [3:0]  IFID_Rs;
  logic [3:0]  IFID_Rt;
  logic        IFID_UseRt;
  logic        Branch_taken;
  logic        md_start;
  logic        md_done;
  logic        PC_WRITE;
  logic        IFID_WRITE;
  logic        IFID_FLUSH;
  logic        IDEX_FLUSH;
  logic        md_abort;
  logic        md_timeout;
  logic [15:0] stall_count;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.BR_FLUSH_CYCLES(BRC), .MD_TIMEOUT(MDT)) dut (
    .clk(clk), .rst(rst),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_Rd(IDEX_Rd),
    .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UseRt(IFID_UseRt),
    .Branch_taken(Branch_taken), .md_start(md_start), .md_done(md_done),
    .PC_WRITE(PC_WRITE), .IFID_WRITE(IFID_WRITE),
    .IFID_FLUSH(IFID_FLUSH), .IDEX_FLUSH(IDEX_FLUSH),
    .md_abort(md_abort), .md_timeout(md_timeout), .stall_count(stall_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: absolute-time bookkeeping instead of a state machine.
  longint cyc;
  longint flush_end;
  bit     md_open;
  longint md_t0;
  int     perf;

  // Last sampled DUT outputs, used for counting scenario-level properties.
  logic last_pc, last_iff, last_to, last_ab;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic idle();
    IDEX_MemRead = 1'b0; IDEX_Rd = 4'd0; IFID_Rs = 4'd0; IFID_Rt = 4'd0;
    IFID_UseRt = 1'b0; Branch_taken = 1'b0; md_start = 1'b0; md_done = 1'b0;
  endtask

  task automatic model_reset();
    cyc = 0; flush_end = -1; md_open = 1'b0; md_t0 = 0; perf = 0;
  endtask

  // Assert reset away from the clock edge, check reset-time outputs, release after an edge.
  task automatic do_reset(input string tag);
    rst = 1'b0;
    #2;
    check({tag, "_rst_outs"}, 32'({PC_WRITE, IFID_WRITE, IFID_FLUSH, IDEX_FLUSH, md_abort, md_timeout}),
          32'(6'b001100));
    check({tag, "_rst_cnt"}, 32'(stall_count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  // One clock cycle: inputs already driven; compare at negedge, advance model at posedge.
  task automatic step(input string tag);
    bit flushing, waiting, running, lu, do_to;
    logic e_pc, e_ifw, e_iff, e_idf, e_ab, e_to;
    @(negedge clk);
    flushing = (cyc <= flush_end);
    waiting  = md_open && !flushing;
    running  = !flushing && !waiting;
    lu = running && IDEX_MemRead && (IDEX_Rd != 4'd0) &&
         ((IDEX_Rd == IFID_Rs) || (IFID_UseRt && (IDEX_Rd == IFID_Rt)));
    e_pc = 1; e_ifw = 1; e_iff = 0; e_idf = 0; e_ab = 0; e_to = 0;
    do_to = waiting && !md_done && (cyc == md_t0 + MDT);
    if (Branch_taken) begin
      e_iff = 1; e_idf = 1; e_ab = waiting;
    end else if (flushing) begin
      e_iff = 1; e_idf = 1;
    end else if (waiting) begin
      if (do_to) e_to = 1;
      else if (!md_done) begin e_pc = 0; e_ifw = 0; e_idf = 1; end
    end else if (md_start || lu) begin
      e_pc = 0; e_ifw = 0; e_idf = 1;
    end
    check(tag, 32'({PC_WRITE, IFID_WRITE, IFID_FLUSH, IDEX_FLUSH, md_abort, md_timeout}),
          32'({e_pc, e_ifw, e_iff, e_idf, e_ab, e_to}));
`ifdef HAZ_PERF_CNT_EN
    check({tag, "_cnt"}, 32'(stall_count), 32'(perf));
    if (!e_pc && perf < 65535) perf++;
`else
    check({tag, "_cnt"}, 32'(stall_count), 32'd0);
`endif
    last_pc = PC_WRITE; last_iff = IFID_FLUSH; last_to = md_timeout; last_ab = md_abort;
    if (Branch_taken) begin
      flush_end = cyc + BRC; md_open = 1'b0;
    end else if (waiting && (md_done || do_to)) begin
      md_open = 1'b0;
    end else if (running && md_start) begin
      md_open = 1'b1; md_t0 = cyc;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    int n_stall, n_to, n_iff, n_ab, to_idx;
    idle();
    rst = 1'b1;
    model_reset();
    #3;
    do_reset("init");
    step("post_reset_run");
    $display("scenario reset checks=%0d errors=%0d", checks, errors);

    // Load-use hazard on Rs, on Rt, and never through register 0.
    IDEX_MemRead = 1; IDEX_Rd = 4'd3; IFID_Rs = 4'd3;
    step("lu_rs_hit");
    check("lu_rs_pc", 32'(last_pc), 32'd0);
    idle(); step("lu_release");
    check("lu_one_cycle", 32'(last_pc), 32'd1);
    IDEX_MemRead = 1; IDEX_Rd = 4'd0; IFID_Rs = 4'd0; IFID_Rt = 4'd0; IFID_UseRt = 1;
    step("lu_r0");
    check("lu_r0_pc", 32'(last_pc), 32'd1);
    IDEX_Rd = 4'd5; IFID_Rs = 4'd2; IFID_Rt = 4'd5; IFID_UseRt = 1;
    step("lu_rt_hit");
    IFID_UseRt = 0;
    step("lu_rt_unused");
    idle();
    $display("scenario load_use checks=%0d errors=%0d", checks, errors);

    // md_done on the 5th cycle after md_start.
    n_stall = 0;
    md_start = 1; step("md_start"); n_stall += !last_pc; md_start = 0;
    for (int i = 1; i <= 5; i++) begin
      md_done = (i == 5);
      step("md_wait");
      n_stall += !last_pc;
    end
    md_done = 0;
    check("md_done_release", 32'(last_pc), 32'd1);
    step("md_after_done");
    check("md_done_stalls", 32'(n_stall), 32'd5);
    $display("scenario md_done checks=%0d errors=%0d", checks, errors);

    // md_done never arrives: timeout.
    n_stall = 0; n_to = 0; to_idx = 0;
    md_start = 1; step("to_start"); n_stall += !last_pc; md_start = 0;
    for (int i = 1; i <= MDT; i++) begin
      step("to_wait");
      n_stall += !last_pc;
      if (last_to) begin n_to++; to_idx = i; end
    end
    step("to_after");
    n_to += last_to;
    check("to_stalls", 32'(n_stall), 32'(MDT));
    check("to_pulses", 32'(n_to), 32'd1);
    check("to_index", 32'(to_idx), 32'(MDT));
    $display("scenario md_timeout checks=%0d errors=%0d", checks, errors);

    // Branch during MD_WAIT: abort pulse and BRC+1 flush cycles.
    md_start = 1; step("ab_start"); md_start = 0;
    step("ab_wait"); step("ab_wait");
    n_iff = 0; n_ab = 0;
    Branch_taken = 1; md_done = 1;
    step("ab_branch"); n_iff += last_iff; n_ab += last_ab;
    Branch_taken = 0; md_done = 0;
    for (int i = 0; i < 4; i++) begin
      step("ab_flush"); n_iff += last_iff; n_ab += last_ab;
    end
    check("ab_iff_cycles", 32'(n_iff), 32'(BRC + 1));
    check("ab_pulses", 32'(n_ab), 32'd1);
    // Branch reload during BR_FLUSH, with md_start and a hazard that must be ignored.
    Branch_taken = 1; step("rl_br1"); step("rl_br2"); Branch_taken = 0;
    md_start = 1; IDEX_MemRead = 1; IDEX_Rd = 4'd1; IFID_Rs = 4'd1;
    step("rl_flush"); step("rl_flush");
    idle(); step("rl_run");
    $display("scenario branch checks=%0d errors=%0d", checks, errors);

    // Reset abandons MD_WAIT and BR_FLUSH.
    md_start = 1; step("rs_md"); md_start = 0; step("rs_md");
    do_reset("mid_md");
    step("rs_run");
    Branch_taken = 1; step("rs_br"); Branch_taken = 0;
    do_reset("mid_br");
    step("rs_run2");
    $display("scenario mid_reset checks=%0d errors=%0d", checks, errors);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      IDEX_MemRead = ($urandom_range(0, 1) == 1);
      IDEX_Rd      = 4'($urandom_range(0, 3));
      IFID_Rs      = 4'($urandom_range(0, 3));
      IFID_Rt      = 4'($urandom_range(0, 3));
      IFID_UseRt   = ($urandom_range(0, 1) == 1);
      Branch_taken = ($urandom_range(0, 15) == 0);
      md_start     = ($urandom_range(0, 7) == 0);
      md_done      = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 499) == 0) do_reset("rand");
      step("rand");
      if (i % 500 == 499) $display("scenario random block %0d checks=%0d errors=%0d", i / 500, checks, errors);
    end
    idle();

`ifdef HAZ_PERF_CNT_EN
    do_reset("perf_start");
    IDEX_MemRead = 1; IDEX_Rd = 4'd2; IFID_Rs = 4'd2;
    for (int i = 0; i < 70000; i++) step("perf");
    check("perf_saturated", 32'(stall_count), 32'h0000FFFF);
    step("perf_hold");
    check("perf_hold_ffff", 32'(stall_count), 32'h0000FFFF);
    idle();
    do_reset("perf_clear");
    $display("scenario perf_counter checks=%0d errors=%0d", checks, errors);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter BR_FLUSH_CYCLES, default 1, number of extra IF/ID flush cycles after a taken branch (legal 1..3).
REQ-002 Parameter MD_TIMEOUT, default 32, maximum multiply/divide wait cycles before forced release (legal 2..255).
REQ-003 clk  in  1  single pipeline clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 IDEX_MemRead  in  1  load instruction currently in the ID/EX register.
REQ-006 IDEX_Rd  in  4  destination register index of the ID/EX instruction.
REQ-007 IFID_Rs, IFID_Rt  in  4 each  source register indices of the IF/ID instruction.
REQ-008 IFID_UseRt  in  1  IF/ID instruction reads Rt.
REQ-009 Branch_taken  in  1  branch resolved taken in MEM stage this cycle.
REQ-010 md_start  in  1  multi-cycle mul/div issued from EX this cycle.
REQ-011 md_done  in  1  mul/div unit result valid.
REQ-012 PC_WRITE, IFID_WRITE  out  1 each  PC and IF/ID register load enables.
REQ-013 IFID_FLUSH, IDEX_FLUSH  out  1 each  bubble-insert requests to the IF/ID and ID/EX registers.
REQ-014 md_abort, md_timeout  out  1 each  single-cycle pulses to the mul/div unit and the status logic.
REQ-015 stall_count  out  16  saturating stall counter (see Configuration).

Function
REQ-016 FSM states SHALL be RUN, BR_FLUSH and MD_WAIT; all outputs are combinational from state and current inputs (zero-cycle latency); state and counters update on rising clk.
REQ-017 Load-use hazard = RUN & IDEX_MemRead & IDEX_Rd!=0 & (IDEX_Rd==IFID_Rs | (IFID_UseRt & IDEX_Rd==IFID_Rt)); when true: PC_WRITE=0, IFID_WRITE=0, IDEX_FLUSH=1 for that cycle only; state stays RUN.
REQ-018 Register index 0 SHALL never cause a load-use stall.
REQ-019 md_start in RUN SHALL move to MD_WAIT and load the wait counter with 0; in MD_WAIT: PC_WRITE=0, IFID_WRITE=0, IDEX_FLUSH=1, counter increments each cycle.
REQ-020 In MD_WAIT, md_done SHALL release stalls in that same cycle and return to RUN next edge.
REQ-021 In MD_WAIT, counter reaching MD_TIMEOUT-1 without md_done SHALL pulse md_timeout for one cycle, release stalls that cycle and return to RUN.
REQ-022 Branch_taken SHALL have top priority in any state: IFID_FLUSH=1, IDEX_FLUSH=1, PC_WRITE=1, IFID_WRITE=1 that cycle; next state BR_FLUSH with flush counter = BR_FLUSH_CYCLES.
REQ-023 Branch_taken while in MD_WAIT SHALL also pulse md_abort for one cycle; md_done/timeout in the same cycle are ignored.
REQ-024 BR_FLUSH: IFID_FLUSH=1, IDEX_FLUSH=1, PC_WRITE=1, IFID_WRITE=1; counter decrements each cycle; leaves to RUN in the cycle the counter reaches 1; load-use and md_start are ignored in BR_FLUSH.
REQ-025 A new Branch_taken during BR_FLUSH SHALL reload the flush counter to BR_FLUSH_CYCLES.
REQ-026 md_start and a load-use hazard in the same RUN cycle: md_start wins (MD_WAIT), stall outputs identical.
REQ-027 With no hazard in RUN: PC_WRITE=1, IFID_WRITE=1, both flushes 0, pulses 0.

Reset
REQ-028 While rst=0: state=RUN, counters=0, stall_count=0, PC_WRITE=0, IFID_WRITE=0, IFID_FLUSH=1, IDEX_FLUSH=1, md_abort=0, md_timeout=0, independent of clk.
REQ-029 Reset asserted mid-MD_WAIT or mid-BR_FLUSH SHALL abandon the operation without an md_abort pulse; first post-reset cycle is RUN.

Configuration
REQ-030 With HAZ_PERF_CNT_EN defined: stall_count increments by 1 every cycle PC_WRITE=0 (rst high), saturates at 16'hFFFF.
REQ-031 Without HAZ_PERF_CNT_EN: no counter flops, stall_count tied to 16'h0000; all other behaviour identical.

Verification
REQ-032 IDEX_MemRead=1, IDEX_Rd=3, IFID_Rs=3 -> exactly one cycle PC_WRITE=0, IDEX_FLUSH=1; same with IDEX_Rd=0 -> no stall.
REQ-033 md_start, md_done on 5th following cycle -> PC_WRITE=0 for 5 cycles, released in the md_done cycle.
REQ-034 md_start, md_done never, MD_TIMEOUT=32 -> 32 stall cycles, md_timeout single pulse on the 32nd, then RUN.
REQ-035 BR_FLUSH_CYCLES=2, Branch_taken during MD_WAIT -> md_abort pulse, IFID_FLUSH high 3 consecutive cycles, then RUN.
REQ-036 HAZ_PERF_CNT_EN defined, preload near 16'hFFFF via 70000 stall cycles -> stall_count holds 16'hFFFF; rst low mid-run -> 0.
